// File: rtl/hsem_task_queue.sv
// Per-channel task FIFO bank for the HSEM subsystem.
// Cores post task words to a channel; the owning core peeks the head and pops in order.
module hsem_task_queue #(
  parameter int TASK_SWITCH_WIDTH = 32,
  parameter int CH_NUM            = 4,
  parameter int CH_SEL_WIDTH      = 2,
  parameter int FIFO_DEPTH        = 4,
  parameter int PTR_WIDTH         = 2
) (
  input  logic                         hclk,
  input  logic                         hresetn,
  input  logic                         wr_en,
  input  logic                         task_en,
  input  logic [CH_SEL_WIDTH-1:0]      wr_ch,
  input  logic [TASK_SWITCH_WIDTH-1:0] ihwdata,
  input  logic                         rd_en,
  input  logic [CH_SEL_WIDTH-1:0]      rd_ch,
  input  logic [CH_NUM-1:0]            irq_en,
  input  logic [CH_NUM-1:0]            ovf_clr,
  output logic [TASK_SWITCH_WIDTH-1:0] tsk_stat,
  output logic [CH_NUM-1:0]            tsk_empty,
  output logic [CH_NUM-1:0]            tsk_full,
  output logic [CH_NUM-1:0]            tsk_ovf,
  output logic [CH_NUM-1:0]            tsk_irq
);

  localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH + 1)'(FIFO_DEPTH);

  logic [TASK_SWITCH_WIDTH-1:0] mem_r    [CH_NUM][FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]         wr_ptr_r [CH_NUM];
  logic [PTR_WIDTH-1:0]         rd_ptr_r [CH_NUM];
  logic [PTR_WIDTH:0]           cnt_r    [CH_NUM];
  logic [CH_NUM-1:0]            ovf_r;

  logic [CH_NUM-1:0]            empty_s;
  logic [CH_NUM-1:0]            full_s;
  logic [CH_NUM-1:0]            wr_hit_s;
  logic [CH_NUM-1:0]            push_s;
  logic [CH_NUM-1:0]            pop_s;
  logic [CH_NUM-1:0]            ovf_set_s;
  logic [TASK_SWITCH_WIDTH-1:0] stat_s;

  // Per-channel status and push/pop acceptance; a same-cycle pop frees a full slot.
  always_comb begin
    empty_s   = '0;
    full_s    = '0;
    wr_hit_s  = '0;
    push_s    = '0;
    pop_s     = '0;
    ovf_set_s = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      empty_s[i]   = (cnt_r[i] == '0);
      full_s[i]    = (cnt_r[i] == DEPTH_C);
      wr_hit_s[i]  = wr_en & task_en & (wr_ch == CH_SEL_WIDTH'(i));
      pop_s[i]     = rd_en & (rd_ch == CH_SEL_WIDTH'(i)) & ~empty_s[i];
      push_s[i]    = wr_hit_s[i] & (~full_s[i] | pop_s[i]);
      ovf_set_s[i] = wr_hit_s[i] & full_s[i] & ~pop_s[i];
    end
  end

  // Head-of-queue peek; out-of-range or empty channels read as zero.
  always_comb begin
    stat_s = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      stat_s = stat_s | (((rd_ch == CH_SEL_WIDTH'(i)) && !empty_s[i]) ?
                         mem_r[i][rd_ptr_r[i]] : '0);
    end
  end

  // FIFO storage, pointers, occupancy and sticky overflow flags.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int i = 0; i < CH_NUM; i++) begin
        for (int j = 0; j < FIFO_DEPTH; j++) begin
          mem_r[i][j] <= '0;
        end
        wr_ptr_r[i] <= '0;
        rd_ptr_r[i] <= '0;
        cnt_r[i]    <= '0;
      end
      ovf_r <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (push_s[i]) begin
          mem_r[i][wr_ptr_r[i]] <= ihwdata;
          wr_ptr_r[i]           <= wr_ptr_r[i] + PTR_WIDTH'(1);
        end
        if (pop_s[i]) begin
          rd_ptr_r[i] <= rd_ptr_r[i] + PTR_WIDTH'(1);
        end
        case ({push_s[i], pop_s[i]})
          2'b10:   cnt_r[i] <= cnt_r[i] + (PTR_WIDTH + 1)'(1);
          2'b01:   cnt_r[i] <= cnt_r[i] - (PTR_WIDTH + 1)'(1);
          default: cnt_r[i] <= cnt_r[i];
        endcase
      end
      // A new overflow outranks a clear arriving in the same cycle.
      ovf_r <= ovf_set_s | (ovf_r & ~ovf_clr);
    end
  end

  assign tsk_stat  = stat_s;
  assign tsk_empty = empty_s;
  assign tsk_full  = full_s;
  assign tsk_ovf   = ovf_r;
  assign tsk_irq   = ~empty_s & irq_en;

endmodule

// File: tb/tb_hsem_task_queue.sv
// Directed self-checking bench for hsem_task_queue.
module tb_hsem_task_queue;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        wr_en;
  logic        task_en;
  logic [1:0]  wr_ch;
  logic [31:0] ihwdata;
  logic        rd_en;
  logic [1:0]  rd_ch;
  logic [3:0]  irq_en;
  logic [3:0]  ovf_clr;
  logic [31:0] tsk_stat;
  logic [3:0]  tsk_empty;
  logic [3:0]  tsk_full;
  logic [3:0]  tsk_ovf;
  logic [3:0]  tsk_irq;

  int errors = 0;
  int checks = 0;

  hsem_task_queue dut (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .wr_en    (wr_en),
    .task_en  (task_en),
    .wr_ch    (wr_ch),
    .ihwdata  (ihwdata),
    .rd_en    (rd_en),
    .rd_ch    (rd_ch),
    .irq_en   (irq_en),
    .ovf_clr  (ovf_clr),
    .tsk_stat (tsk_stat),
    .tsk_empty(tsk_empty),
    .tsk_full (tsk_full),
    .tsk_ovf  (tsk_ovf),
    .tsk_irq  (tsk_irq)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_en   = 1'b0;
    task_en = 1'b0;
    rd_en   = 1'b0;
    ovf_clr = 4'h0;
    #1;
  endtask

  task automatic cyc();
    @(posedge hclk);
    #1;
    idle();
  endtask

  task automatic push(input logic [1:0] ch, input logic [31:0] d);
    wr_en = 1'b1; task_en = 1'b1; wr_ch = ch; ihwdata = d;
    cyc();
  endtask

  task automatic pop(input logic [1:0] ch);
    rd_en = 1'b1; rd_ch = ch;
    cyc();
  endtask

  initial begin
    hresetn = 1'b0; wr_ch = 2'd0; ihwdata = 32'h0; rd_ch = 2'd0; irq_en = 4'hF;
    idle();
    repeat (3) @(posedge hclk);
    #1;
    check("rst_empty", 32'(tsk_empty), 32'hF);
    check("rst_full",  32'(tsk_full),  32'h0);
    check("rst_ovf",   32'(tsk_ovf),   32'h0);
    check("rst_irq",   32'(tsk_irq),   32'h0);
    for (int c = 0; c < 4; c++) begin
      rd_ch = 2'(c); #1;
      check("rst_stat", tsk_stat, 32'h0);
    end
    hresetn = 1'b1;
    irq_en  = 4'h0;
    #1;

    // In-order push/pop on ch1.
    push(2'd1, 32'h11); push(2'd1, 32'h22); push(2'd1, 32'h33); push(2'd1, 32'h44);
    check("ch1_full",  32'(tsk_full),  32'h2);
    check("ch1_empty", 32'(tsk_empty), 32'hD);
    rd_ch = 2'd1; #1;
    check("ch1_head0", tsk_stat, 32'h11); pop(2'd1);
    check("ch1_head1", tsk_stat, 32'h22); pop(2'd1);
    check("ch1_head2", tsk_stat, 32'h33); pop(2'd1);
    check("ch1_head3", tsk_stat, 32'h44); pop(2'd1);
    check("ch1_drained_stat",  tsk_stat, 32'h0);
    check("ch1_drained_empty", 32'(tsk_empty), 32'hF);
    pop(2'd1);
    check("empty_pop_no_ovf", 32'(tsk_ovf), 32'h0);

    // Overflow on ch2, clear/set collision, lone clear.
    for (int k = 0; k < 4; k++) push(2'd2, 32'hA0 + 32'(k));
    push(2'd2, 32'hDEAD);
    check("ch2_ovf", 32'(tsk_ovf), 32'h4);
    wr_en = 1'b1; task_en = 1'b1; wr_ch = 2'd2; ihwdata = 32'hBEEF; ovf_clr = 4'h4;
    cyc();
    check("ovf_set_wins", 32'(tsk_ovf), 32'h4);
    ovf_clr = 4'h4;
    cyc();
    check("ovf_cleared", 32'(tsk_ovf), 32'h0);
    rd_ch = 2'd2;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("ch2_unchanged", tsk_stat, 32'hA0 + 32'(k));
      pop(2'd2);
    end
    check("ch2_empty", 32'(tsk_empty), 32'hF);

    // Full channel push+pop, empty channel push+pop.
    for (int k = 1; k <= 4; k++) push(2'd0, 32'(k));
    wr_en = 1'b1; task_en = 1'b1; wr_ch = 2'd0; ihwdata = 32'h55; rd_en = 1'b1; rd_ch = 2'd0;
    cyc();
    check("full_pp_no_ovf", 32'(tsk_ovf),  32'h0);
    check("full_pp_full",   32'(tsk_full), 32'h1);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("ch0_order", tsk_stat, (k == 3) ? 32'h55 : 32'(k + 2));
      pop(2'd0);
    end
    wr_en = 1'b1; task_en = 1'b1; wr_ch = 2'd3; ihwdata = 32'h66; rd_en = 1'b1; rd_ch = 2'd3;
    cyc();
    check("ch3_stat",  tsk_stat, 32'h66);
    check("ch3_empty", 32'(tsk_empty), 32'h7);
    check("ch3_full",  32'(tsk_full), 32'h0);
    // Push ch0 while popping ch3: independent channels.
    wr_en = 1'b1; task_en = 1'b1; wr_ch = 2'd0; ihwdata = 32'h99; rd_en = 1'b1; rd_ch = 2'd3;
    cyc();
    check("xch_empty", 32'(tsk_empty), 32'hE);
    rd_ch = 2'd0; #1;
    check("xch_stat", tsk_stat, 32'h99);
    pop(2'd0);

    // Interrupt masking and drop timing.
    irq_en = 4'b0101;
    push(2'd0, 32'h77); push(2'd1, 32'h88);
    check("irq_masked", 32'(tsk_irq), 32'h1);
    rd_en = 1'b1; rd_ch = 2'd0; #1;
    check("irq_hold_in_pop", 32'(tsk_irq), 32'h1);
    cyc();
    check("irq_dropped", 32'(tsk_irq), 32'h0);
    pop(2'd1);
    irq_en = 4'h0;

    // Asynchronous reset mid-operation.
    push(2'd1, 32'hC1); push(2'd1, 32'hC2);
    rd_ch = 2'd1;
    #2 hresetn = 1'b0;
    #1;
    check("async_rst_empty", 32'(tsk_empty), 32'hF);
    check("async_rst_stat",  tsk_stat, 32'h0);
    @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk); #1;

    // Pointer wrap over three fill/drain rounds.
    rd_ch = 2'd2;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) push(2'd2, 32'(r * 16 + k + 1));
      check("wrap_not_full", 32'(tsk_full), 32'h0);
      push(2'd2, 32'(r * 16 + 4));
      check("wrap_full", 32'(tsk_full), 32'h4);
      for (int k = 0; k < 4; k++) begin
        #1;
        check("wrap_data", tsk_stat, 32'(r * 16 + k + 1));
        pop(2'd2);
      end
      check("wrap_empty", 32'(tsk_empty), 32'hF);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
